// File: rtl/mem_store_buffer_if.sv
// Pipeline-side store/load handshake plus data-memory port of the posted-store buffer.
// The slave modport is the buffer itself; master is the pipeline/memory environment.
interface mem_store_buffer_if #(
  parameter int PTR_W = 2
);
  logic              st_valid;
  logic              st_ready;
  logic [31:0]       st_addr;
  logic [31:0]       st_data;
  logic              ld_valid;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_data;
  logic              ld_fwd;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_rdata;
  logic              empty;
  logic [PTR_W:0]    count;

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
    output st_ready, ld_data, ld_fwd, mem_addr, mem_wdata, mem_read, mem_write,
           empty, count
  );

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rdata,
    input  st_ready, ld_data, ld_fwd, mem_addr, mem_wdata, mem_read, mem_write,
           empty, count
  );
endinterface

// File: rtl/mem_store_buffer.sv
// Posted-store FIFO in front of a single-port data memory: loads own the port and
// forward from the youngest matching pending store; stores drain on idle cycles.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_store_buffer_if.slave   bus
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic             push, pop, empty, ld_active, hit;
  logic [31:0]      hit_data;
  logic [PTR_W-1:0] idx;
  logic [3:0]       unused_addr_lsb;

  assign unused_addr_lsb = {bus.st_addr[1:0], bus.ld_addr[1:0]};

  assign empty     = (count_q == '0);
  assign ld_active = rst & bus.ld_valid;
  // A slot freed by this cycle's drain only becomes usable next cycle.
  assign bus.st_ready = (count_q != (PTR_W+1)'(DEPTH));
  assign push      = bus.st_valid & bus.st_ready;
  assign pop       = rst & ~empty & ~bus.ld_valid;

  // Walk oldest to youngest so the last hit wins; the entry being pushed is not visible.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if (((PTR_W+1)'(k) < count_q) && (addr_q[idx] == bus.ld_addr[31:2])) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  always_comb begin
    bus.mem_write = pop;
    bus.mem_read  = ld_active & ~hit;
    bus.ld_fwd    = ld_active & hit;
    bus.ld_data   = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (ld_active) begin
      bus.ld_data  = hit ? hit_data : bus.mem_rdata;
      bus.mem_addr = bus.ld_addr;
    end else if (pop) begin
      bus.mem_addr  = {addr_q[rd_ptr_q], 2'b00};
      bus.mem_wdata = data_q[rd_ptr_q];
    end
  end

  assign bus.empty = empty;
  assign bus.count = count_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; validity comes from count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.st_addr[31:2];
      data_q[wr_ptr_q] <= bus.st_data;
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer with a small word-addressed memory model.
module tb_mem_store_buffer;
  logic clk, rst_n;
  logic tb_clr, tb_wr;
  logic [9:0]  tb_idx;
  logic [31:0] tb_val;
  logic [31:0] mem [0:1023];
  int checks = 0, failures = 0;

  mem_store_buffer_if #(.PTR_W(2)) bus ();

  mem_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end else if (tb_wr) begin
      mem[tb_idx] <= tb_val;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; tb_clr = 1'b1; tb_wr = 1'b0; tb_idx = '0; tb_val = '0;
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0;
    tick(); tick();
    tb_clr = 1'b0;
    settle();
    chk("rst_empty", bus.empty, 1);
    chk("rst_count", bus.count, 0);
    chk("rst_st_ready", bus.st_ready, 1);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_ld_fwd", bus.ld_fwd, 0);
    chk("rst_ld_data", bus.ld_data, 0);
    tick();
    rst_n = 1'b1;

    // single store drains the cycle after it is accepted
    bus.st_valid = 1'b1; bus.st_addr = 32'h10; bus.st_data = 32'hAABBCCDD;
    settle();
    chk("single_no_early_write", bus.mem_write, 0);
    tick();
    bus.st_valid = 1'b0;
    settle();
    chk("single_mem_write", bus.mem_write, 1);
    chk("single_mem_addr", bus.mem_addr, 32'h10);
    chk("single_mem_wdata", bus.mem_wdata, 32'hAABBCCDD);
    chk("single_count", bus.count, 1);
    tick();
    settle();
    chk("single_mem4", mem[4], 32'hAABBCCDD);
    chk("single_empty", bus.empty, 1);

    // forwarding with ld_valid held, including same-cycle push invisibility
    tick();
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h20;
    bus.st_valid = 1'b1; bus.st_addr = 32'h20; bus.st_data = 32'h1;
    settle();
    chk("samecyc_fwd", bus.ld_fwd, 0);
    chk("samecyc_mem_read", bus.mem_read, 1);
    chk("samecyc_ld_data", bus.ld_data, 0);
    tick();
    bus.st_data = 32'h2;
    settle();
    chk("fwd_old_data", bus.ld_data, 32'h1);
    chk("fwd_old_flag", bus.ld_fwd, 1);
    tick();
    bus.st_valid = 1'b0; bus.ld_addr = 32'h22;
    tb_wr = 1'b1; tb_idx = 10'd16; tb_val = 32'h55;
    settle();
    chk("fwd_young_data", bus.ld_data, 32'h2);
    chk("fwd_young_flag", bus.ld_fwd, 1);
    chk("fwd_mem_read", bus.mem_read, 0);
    chk("fwd_count", bus.count, 2);
    chk("fwd_blocks_drain", bus.mem_write, 0);

    // miss goes to memory
    tick();
    tb_wr = 1'b0; bus.ld_addr = 32'h40;
    settle();
    chk("miss_ld_data", bus.ld_data, 32'h55);
    chk("miss_fwd", bus.ld_fwd, 0);
    chk("miss_mem_read", bus.mem_read, 1);
    chk("miss_mem_write", bus.mem_write, 0);
    chk("miss_mem_addr", bus.mem_addr, 32'h40);
    tick();
    bus.ld_valid = 1'b0;
    settle();
    chk("drain0_addr", bus.mem_addr, 32'h20);
    chk("drain0_wdata", bus.mem_wdata, 32'h1);
    tick();
    settle();
    chk("drain1_wdata", bus.mem_wdata, 32'h2);
    tick();
    settle();
    chk("drain_empty", bus.empty, 1);
    chk("lastwins_mem8", mem[8], 32'h2);

    // fill to DEPTH behind a held load, then release
    tick();
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      bus.st_valid = 1'b1; bus.st_addr = 32'h100 + 32'(4*i); bus.st_data = 32'(i+1);
      tick();
    end
    bus.st_addr = 32'h110; bus.st_data = 32'h5;
    settle();
    chk("full_st_ready", bus.st_ready, 0);
    chk("full_count", bus.count, 4);
    tick();
    settle();
    chk("full_hold_count", bus.count, 4);
    tick();
    bus.ld_valid = 1'b0;
    settle();
    chk("full_d1_write", bus.mem_write, 1);
    chk("full_d1_addr", bus.mem_addr, 32'h100);
    chk("full_d1_no_free", bus.st_ready, 0);
    tick();
    settle();
    chk("full_d2_count", bus.count, 3);
    chk("full_d2_ready", bus.st_ready, 1);
    chk("full_d2_addr", bus.mem_addr, 32'h104);
    tick();
    bus.st_valid = 1'b0;
    settle();
    chk("full_d3_count", bus.count, 3);
    chk("full_d3_addr", bus.mem_addr, 32'h108);
    tick();
    settle();
    chk("full_d4_addr", bus.mem_addr, 32'h10C);
    tick();
    settle();
    chk("full_d5_addr", bus.mem_addr, 32'h110);
    chk("full_d5_wdata", bus.mem_wdata, 32'h5);
    tick();
    settle();
    chk("full_empty", bus.empty, 1);
    for (int i = 0; i < 5; i++) chk("full_mem", mem[64+i], 32'(i+1));

    // async reset with stores pending discards them
    tick();
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h300;
    for (int i = 0; i < 3; i++) begin
      bus.st_valid = 1'b1; bus.st_addr = 32'h200 + 32'(4*i); bus.st_data = 32'hA0 + 32'(i);
      tick();
    end
    bus.st_valid = 1'b0;
    settle();
    chk("prerst_count", bus.count, 3);
    tick();
    rst_n = 1'b0; bus.ld_valid = 1'b0;
    #1;
    chk("midrst_count", bus.count, 0);
    chk("midrst_empty", bus.empty, 1);
    chk("midrst_mem_write", bus.mem_write, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("postrst_no_write", bus.mem_write, 0);
      tick();
    end
    chk("postrst_mem128", mem[128], 0);

    // wrap-around: pushes alternate with loads of the same address
    for (int i = 0; i < 10; i++) begin
      bus.ld_valid = 1'b0;
      bus.st_valid = 1'b1; bus.st_addr = 32'h400 + 32'(4*(i%3)); bus.st_data = 32'h1000 + 32'(i);
      tick();
      bus.st_valid = 1'b0;
      bus.ld_valid = 1'b1; bus.ld_addr = 32'h400 + 32'(4*(i%3));
      settle();
      chk("wrap_ld_data", bus.ld_data, 32'h1000 + 32'(i));
      chk("wrap_ld_fwd", bus.ld_fwd, 1);
      tick();
    end
    bus.ld_valid = 1'b0;
    for (int n = 0; n < 20 && !bus.empty; n++) tick();
    chk("wrap_drained", bus.empty, 1);
    chk("wrap_mem_slot0", mem[256], 32'h1009);
    chk("wrap_mem_slot1", mem[257], 32'h1007);
    chk("wrap_mem_slot2", mem[258], 32'h1008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Posted-store buffer between the EX/MEM pipeline register and the single-port data memory.
- Stores are queued in a small FIFO and drained to memory on cycles when no load is using the memory port.
- Loads are served in the same cycle: from the youngest matching buffered store (forwarding), otherwise by a combinational memory read.
- Lets the pipeline retire stores without stalling, except when the buffer is full.

Parameters:
DEPTH, 4, number of buffered stores (power of 2, >=2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
st_valid  input  1  store request from MEM stage
st_addr  input  32  store byte address (word-aligned; bits[1:0] ignored)
st_data  input  32  store data
st_ready  output  1  buffer can accept a store this cycle
ld_valid  input  1  load request from MEM stage
ld_addr  input  32  load byte address (bits[1:0] ignored)
ld_data  output  32  load result, valid same cycle as ld_valid
ld_fwd  output  1  ld_data came from the buffer (debug/perf)
mem_addr  output  32  address to data memory
mem_wdata  output  32  write data to data memory
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable (memory writes on rising clk)
mem_rdata  input  32  combinational read data from memory
empty  output  1  no stores pending
count  output  PTR_W+1  number of pending stores

Behaviour:
- State: entry arrays addr[DEPTH], data[DEPTH]; wr_ptr, rd_ptr (PTR_W bits, wrap mod DEPTH); count (0..DEPTH).
- Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0; pending stores discarded; entry contents need not be cleared.
- Outputs in reset: empty=1, st_ready=1, mem_write=0, mem_read=0, ld_fwd=0, ld_data=0.
- st_ready = (count != DEPTH). A drain in the same cycle does not free a slot for a push.
- Push: st_valid & st_ready at a rising edge writes the entry at wr_ptr and advances wr_ptr.
- st_valid while !st_ready: store not accepted; upstream holds it and stalls.
- Load path (combinational):
  - Match = entry valid and entry addr[31:2] == ld_addr[31:2].
  - Any match: ld_data = data of the youngest matching entry (closest to wr_ptr-1), ld_fwd=1, mem_read=0.
  - No match: mem_read=1, mem_addr=ld_addr, ld_data=mem_rdata, ld_fwd=0.
  - ld_valid=0: ld_data=0, ld_fwd=0, mem_read=0.
- Drain (port arbitration, loads have priority):
  - mem_write = !empty & !ld_valid; then mem_addr=addr[rd_ptr], mem_wdata=data[rd_ptr].
  - At that edge the head is popped (rd_ptr+1).
  - A forwarded load (mem_read=0) still blocks the drain that cycle.
- Latency: a store accepted at edge N is written to memory no earlier than edge N+1.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Simultaneous st_valid and ld_valid: store accepted per the rules above. The load does not see the store being pushed in that same cycle, and the drain is blocked.
- Count update: count += push - pop. count never exceeds DEPTH or goes below 0.
- When mem_write=0 and ld_valid=0: mem_addr=0, mem_wdata=0.

Test Plan:
- Reset then idle: rst=0 mid-run with 3 stores pending -> count=0, empty=1, mem_write=0 immediately; after release, no stale writes to memory.
- Single store st_addr=0x10, st_data=0xAABBCCDD, no loads -> next cycle mem_write=1, mem_addr=0x10, mem_wdata=0xAABBCCDD; memory word 4 holds it after that edge; empty=1.
- Forwarding: push 0x20←0x1 then 0x20←0x2 while ld_valid held high, then load 0x22 -> ld_data=0x2, ld_fwd=1, mem_read=0, count=2.
- Miss: buffer holds 0x20, load 0x40 with memory word=0x55 -> ld_data=0x55, ld_fwd=0, mem_read=1, mem_write=0.
- Full: DEPTH=4, ld_valid held high, push 5 stores -> st_ready=0 after the 4th; 5th held. Release ld_valid -> drain order 1,2,3,4 on consecutive cycles. 5th accepted the cycle after the first pop and written last.
- Wrap-around: push/drain 10 stores alternating with loads -> pointers wrap correctly; memory contents match program order; a last-write-wins check on a repeated address passes.
